// File: rtl/intadc_cmd_sequencer.sv
// intadc_cmd_sequencer: drives single-beat conversion commands to the internal ADC
// from a programmable channel sequence, checks the channel order of the responses
// and forwards samples downstream through a back-pressured FIFO. Every command in
// flight holds a reserved FIFO slot, so a response can always be stored.
module intadc_cmd_sequencer #(
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clock_clk,
    input  logic             reset_sink_reset_n,
    input  logic             ctrl_start,
    input  logic             ctrl_stop,
    input  logic             ctrl_continuous,
    input  logic [CNT_W-1:0] ctrl_num_samples,
    input  logic [1:0]       ctrl_seq_len,
    input  logic [19:0]      ctrl_seq_chan,
    output logic             status_busy,
    output logic             status_error,
    output logic             command_valid,
    output logic [4:0]       command_channel,
    output logic             command_startofpacket,
    output logic             command_endofpacket,
    input  logic             command_ready,
    input  logic             response_valid,
    input  logic [4:0]       response_channel,
    input  logic [11:0]      response_data,
    input  logic             response_startofpacket,
    input  logic             response_endofpacket,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [4:0]       sample_channel,
    output logic [11:0]      sample_data,
    output logic             sample_last
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int FCW = FAW + 1;
    localparam int QAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state, next_state;
    logic                   stop_pend;
    logic                   cont_r;
    logic [CNT_W-1:0]       num_r;
    logic [1:0]             seq_len_r;
    logic [3:0][4:0]        seq_chan_r;
    logic [1:0]             slot;
    logic [CNT_W-1:0]       issued;
    logic [CNT_W-1:0]       resp_cnt;
    logic [OW-1:0]          outstanding;
    logic [4:0]             exp_q [MAX_OUTSTANDING];
    logic [QAW-1:0]         q_wr, q_rd;
    logic [17:0]            fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]         f_wr, f_rd;
    logic [FCW-1:0]         f_cnt;
    logic                   err;

    logic start_ok, accept, resp_hit, resp_bad, push, pop, room, cmd_ok;
    logic unused_ok;

    assign unused_ok = ^{response_startofpacket, response_endofpacket};

    assign start_ok = ctrl_start && (state == IDLE) && (ctrl_continuous || (ctrl_num_samples != '0));
    assign accept   = command_valid && command_ready;
    assign resp_hit = response_valid && (outstanding != '0);
    assign resp_bad = response_valid && ((outstanding == '0) || (response_channel != exp_q[q_rd]));
    assign push     = resp_hit;
    assign pop      = sample_valid && sample_ready;
    assign room     = (SW'(outstanding) + SW'(f_cnt)) < SW'(FIFO_DEPTH);
    assign cmd_ok   = (state == ISSUE) && (outstanding < OW'(MAX_OUTSTANDING)) && room &&
                      (cont_r || (issued != num_r));

    assign command_channel       = command_valid ? seq_chan_r[slot] : 5'd0;
    assign command_startofpacket = command_valid;
    assign command_endofpacket   = command_valid;
    assign status_busy           = (state != IDLE);
    assign status_error          = err;
    assign sample_valid          = (f_cnt != '0);
    assign sample_last           = sample_valid & fifo_mem[f_rd][17];
    assign sample_channel        = sample_valid ? fifo_mem[f_rd][16:12] : 5'd0;
    assign sample_data           = sample_valid ? fifo_mem[f_rd][11:0] : 12'd0;

    // State register
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) state <= IDLE;
        else                     state <= next_state;
    end

    // Command issue and state transitions; a stop never withdraws a beat already offered
    always_comb begin
        next_state    = state;
        command_valid = cmd_ok;
        case (state)
            IDLE:  if (start_ok) next_state = ISSUE;
            ISSUE: begin
                if ((ctrl_stop || stop_pend) && !(command_valid && !command_ready))
                    next_state = DRAIN;
                else if (accept && !cont_r && ((issued + CNT_W'(1)) == num_r))
                    next_state = DRAIN;
            end
            DRAIN: if ((outstanding == '0) && (f_cnt == '0)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Acquisition setup, sequence position, burst counters, pending stop and sticky error
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            cont_r     <= 1'b0;
            num_r      <= '0;
            seq_len_r  <= '0;
            seq_chan_r <= '0;
            slot       <= '0;
            issued     <= '0;
            resp_cnt   <= '0;
            stop_pend  <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (start_ok) begin
                cont_r     <= ctrl_continuous;
                num_r      <= ctrl_num_samples;
                seq_len_r  <= ctrl_seq_len;
                seq_chan_r <= ctrl_seq_chan;
                slot       <= '0;
                issued     <= '0;
                resp_cnt   <= '0;
                err        <= 1'b0;
            end else begin
                if (accept) begin
                    slot <= (slot == seq_len_r) ? 2'd0 : slot + 2'd1;
                    if (!cont_r) issued <= issued + CNT_W'(1);
                end
                if (resp_hit && !cont_r) resp_cnt <= resp_cnt + CNT_W'(1);
                if (resp_bad) err <= 1'b1;
            end
            if (next_state != ISSUE)
                stop_pend <= 1'b0;
            else if (state == ISSUE && ctrl_stop && command_valid && !command_ready)
                stop_pend <= 1'b1;
        end
    end

    // Outstanding-command count and expected-channel queue
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            outstanding <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) exp_q[i] <= '0;
        end else begin
            case ({accept, resp_hit})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            if (accept) begin
                exp_q[q_wr] <= seq_chan_r[slot];
                q_wr <= (q_wr == QAW'(MAX_OUTSTANDING - 1)) ? '0 : q_wr + QAW'(1);
            end
            if (resp_hit)
                q_rd <= (q_rd == QAW'(MAX_OUTSTANDING - 1)) ? '0 : q_rd + QAW'(1);
        end
    end

    // Sample FIFO: responses pushed, downstream handshake pops
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            f_wr  <= '0;
            f_rd  <= '0;
            f_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[f_wr] <= {(!cont_r && ((resp_cnt + CNT_W'(1)) == num_r)),
                                   response_channel, response_data};
                f_wr <= f_wr + FAW'(1);
            end
            if (pop) f_rd <= f_rd + FAW'(1);
            case ({push, pop})
                2'b10:   f_cnt <= f_cnt + FCW'(1);
                2'b01:   f_cnt <= f_cnt - FCW'(1);
                default: f_cnt <= f_cnt;
            endcase
        end
    end

endmodule
